rv_decode_stage: RTL
====================

# rv_decode_stage

Registered, parametrised RV32I decode stage that sits between fetch and execute. It replaces the purely combinational decoder with a valid/ready pipeline stage. It adds:
- full I/S/B/U/J immediate generation
- an optional M-extension multiply decode
- illegal-instruction detection
- a flush input
- load-use hazard bubble insertion, with a bubble counter for performance monitoring

## Interface

Parameters:
- XLEN, 32: datapath width, 32 or 64. Immediates and the PC are sign-extended to XLEN. Only RV32I opcodes are decoded.
- ENABLE_M, 0: when 1, decode MUL/MULH/MULHSU/MULHU (funct7=0000001). DIV/REM are always illegal.
- CNT_W, 32: width of the bubble counter.

Ports:
- clk  in  1  single clock. All state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards the held instruction; has priority over everything except rst.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage accepts the beat this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes the bundle.
- out_pc  out  XLEN  registered PC.
- out_rd, out_rs1, out_rs2  out  5 each  register fields.
- out_funct3  out  3  funct3 field.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  4  ALU operation, encoded in rv_decode_pkg.
- out_reg_write, out_alu_src, out_jump, out_jalr, out_branch, out_mem_read, out_mem_write, out_illegal  out  1 each  control flags.
- bubble_count  out  CNT_W  number of load-use bubbles inserted. Saturates at all-ones.

## Operation

- ALU op encoding: ADD=0, SUB=1, OR=2, XOR=3, AND=4, SRA=5, SRL=6, SLL=7, SLT=8, SLTU=9, PASSB=10 (LUI), MUL=11, MULH=12, MULHSU=13, MULHU=14.
- ALU op by instruction class:
  - AUIPC, JAL, JALR, loads, stores: ADD.
  - Branches: SUB.
  - SLT/SLTI and SLTU/SLTIU: their own codes (8, 9).
- Immediates:
  - I: instr[31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All are sign-extended from bit 31 to XLEN. R-type instructions give imm=0.
- out_alu_src=1 for OP-IMM, load, store, LUI, AUIPC.
- Register-source usage for hazard checks:
  - rs1 is used by R, OP-IMM, load, store, branch, JALR.
  - rs2 is used by R, store, branch.
- FENCE (0001111) decodes as a NOP: all write/memory/branch flags are 0 and out_illegal=0.
- out_illegal=1 for any of the following:
  - instr[1:0]≠11, an unknown opcode, or SYSTEM (1110011).
  - R-type funct7 not in {0000000, 0100000 with funct3∈{000,101}, 0000001 with ENABLE_M and funct3∈{000..011}}.
  - SLLI with funct7≠0; SRLI/SRAI with funct7∉{0000000,0100000}.
  - Load funct3∉{000,001,010,100,101}; store funct3∉{000,001,010}.
  - Branch funct3∈{010,011}; JALR funct3≠000.
- When out_illegal=1: out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump and out_jalr are forced to 0, out_valid is still asserted, and field outputs are passed through.
- Load-use hazard is true when all of the following hold in the same cycle:
  - out_valid and out_ready are both 1, and out_mem_read=1.
  - out_rd≠0.
  - in_valid=1, and in_instr uses rs1 or rs2 equal to out_rd.
- When the hazard is true: in_ready=0, the next cycle has out_valid=0 (a bubble), and bubble_count increments. The following cycle accepts the beat normally.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).

## Timing

- Reset: every output register clears to 0 (out_valid=0, bubble_count=0, all fields and flags 0). in_ready=0 while rst=1.
- Latency: 1 cycle from an accepted beat to out_valid. Throughput is 1 instruction/cycle when there is no hazard. in_ready is combinational from out_ready; there is no skid buffer.
- While out_valid && !out_ready, all out_* signals hold stable.
- Simultaneous consume and accept: the new bundle replaces the old one on the same edge.
- flush=1: out_valid=0 next cycle and in_ready=0 this cycle. Any pending bubble is cancelled and bubble_count does not increment.
- rst asserted mid-operation: the held bundle is dropped on the next edge.
- bubble_count saturates; it never wraps.

## Structure

- Package rv_decode_pkg holds:
  - opcode constants (LOAD, STORE, OP, OP_IMM, BRANCH, JAL, JALR, LUI, AUIPC, FENCE, SYSTEM).
  - the alu_op_t 4-bit enum.
  - the imm_type_t enum (I, S, B, U, J, NONE).
- Sub-module rv_decode_comb is purely combinational: instruction → fields, imm, alu_op, flags, illegal, uses_rs1/uses_rs2. rv_decode_stage holds the pipeline register, handshake, hazard detection and counter.

## Test plan

- Reset: hold rst for 2 cycles with in_valid=1 → in_ready=0, out_valid=0, out_imm=0, bubble_count=0.
- ADDI x1,x0,-1 (0xFFF00093), out_ready=1 → next cycle out_valid=1, out_rd=1, out_imm=0xFFFFFFFF, out_alu_op=ADD, out_alu_src=1, out_reg_write=1.
- JAL x1,-4 (0xFFDFF0EF) → out_imm=0xFFFFFFFC, out_jump=1, out_reg_write=1. BEQ x1,x2,+8 (0x00208463) → out_imm=8, out_branch=1, out_alu_op=SUB, out_reg_write=0.
- LW x5,0(x1) (0x0000A283) then ADD x6,x5,x5 (0x00528333), back-to-back with out_ready=1 → LW emitted, one cycle out_valid=0, then ADD emitted, bubble_count=1. Repeat with rd=x0 → no bubble.
- With ENABLE_M=0, send 0x02000033 → out_illegal=1, out_reg_write=0. With ENABLE_M=1 → out_alu_op=MUL, out_illegal=0.
- Backpressure: hold out_ready=0 for 3 cycles → outputs stable and in_ready=0. Assert flush while in_valid=1 → out_valid=0 next cycle and the input beat is not accepted.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared types and helpers for the RV32I decode stage.
// Opcodes, ALU op encoding, immediate formats and control-flag bundle.
package rv_decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_OR     = 4'd2,
        ALU_XOR    = 4'd3,
        ALU_AND    = 4'd4,
        ALU_SRA    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SLT    = 4'd8,
        ALU_SLTU   = 4'd9,
        ALU_PASSB  = 4'd10,
        ALU_MUL    = 4'd11,
        ALU_MULH   = 4'd12,
        ALU_MULHSU = 4'd13,
        ALU_MULHU  = 4'd14
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_t;

    typedef struct packed {
        logic reg_write;
        logic alu_src;
        logic jump;
        logic jalr;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic illegal;
    } ctrl_t;

    function automatic logic [31:0] imm32(
        input logic [31:0] i,
        input imm_type_t   t
    );
        case (t)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7],
                             i[30:25], i[11:8], 1'b0};
            IMM_U:   return {i[31:12], 12'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12],
                             i[20], i[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

    // Base-ISA funct3 mapping shared by OP and OP-IMM.
    function automatic alu_op_t f3_alu(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_decode_if.sv
// Fetch-to-execute bundle around the decode stage.
// slave is the stage side; master is the fetch/execute side.
interface rv_decode_if
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [XLEN-1:0] out_imm;
    alu_op_t         out_alu_op;
    logic            out_reg_write;
    logic            out_alu_src;
    logic            out_jump;
    logic            out_jalr;
    logic            out_branch;
    logic            out_mem_read;
    logic            out_mem_write;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc,
        output out_rd, out_rs1, out_rs2, out_funct3,
        output out_imm, out_alu_op,
        output out_reg_write, out_alu_src, out_jump,
        output out_jalr, out_branch, out_mem_read,
        output out_mem_write, out_illegal
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc,
        input  out_rd, out_rs1, out_rs2, out_funct3,
        input  out_imm, out_alu_op,
        input  out_reg_write, out_alu_src, out_jump,
        input  out_jalr, out_branch, out_mem_read,
        input  out_mem_write, out_illegal
    );
endinterface

// File: rtl/rv_decode_comb.sv
// Combinational RV32I(+M) decoder: fields, immediate, ALU op,
// control flags, illegal detection and register-source usage.
module rv_decode_comb
    import rv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0]     instr,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [XLEN-1:0] imm,
    output alu_op_t         alu_op,
    output ctrl_t           ctrl,
    output logic            uses_rs1,
    output logic            uses_rs2
);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [31:0] imm_w;
    imm_type_t  it;
    logic       ill;

    assign opc    = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct3 = f3;
    assign imm_w  = imm32(instr, it);
    assign imm    = XLEN'($signed(imm_w));

    always_comb begin
        alu_op   = ALU_ADD;
        it       = IMM_NONE;
        ctrl     = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        ill      = 1'b0;
        unique case (1'b1)
            (opc == OPC_OP): begin
                ctrl.reg_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                unique case (1'b1)
                    (f7 == 7'b0000000):
                        alu_op = f3_alu(f3);
                    (f7 == 7'b0100000 && f3 == 3'b000):
                        alu_op = ALU_SUB;
                    (f7 == 7'b0100000 && f3 == 3'b101):
                        alu_op = ALU_SRA;
                    (f7 == 7'b0000001 && ENABLE_M && !f3[2]):
                        alu_op = alu_op_t'(4'd11 + {2'b00, f3[1:0]});
                    default:
                        ill = 1'b1;
                endcase
            end
            (opc == OPC_OP_IMM): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                uses_rs1       = 1'b1;
                it             = IMM_I;
                alu_op         = f3_alu(f3);
                if (f3 == 3'b001 && f7 != 7'b0)
                    ill = 1'b1;
                if (f3 == 3'b101) begin
                    if (f7 == 7'b0100000)
                        alu_op = ALU_SRA;
                    else if (f7 != 7'b0)
                        ill = 1'b1;
                end
            end
            (opc == OPC_LOAD): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.mem_read  = 1'b1;
                uses_rs1       = 1'b1;
                it             = IMM_I;
                ill = !(f3 inside {3'b000, 3'b001, 3'b010,
                                   3'b100, 3'b101});
            end
            (opc == OPC_STORE): begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                it             = IMM_S;
                ill = f3[2] || (f3[1:0] == 2'b11);
            end
            (opc == OPC_BRANCH): begin
                ctrl.branch = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                it          = IMM_B;
                alu_op      = ALU_SUB;
                ill         = (f3[2:1] == 2'b01);
            end
            (opc == OPC_JAL): begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                it             = IMM_J;
            end
            (opc == OPC_JALR): begin
                ctrl.reg_write = 1'b1;
                ctrl.jalr      = 1'b1;
                uses_rs1       = 1'b1;
                it             = IMM_I;
                ill            = (f3 != 3'b000);
            end
            (opc == OPC_LUI): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                it             = IMM_U;
                alu_op         = ALU_PASSB;
            end
            (opc == OPC_AUIPC): begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                it             = IMM_U;
            end
            (opc == OPC_FENCE): begin
                it = IMM_I;
            end
            (opc == OPC_SYSTEM): begin
                ill = 1'b1;
            end
            default: begin
                ill = 1'b1;
            end
        endcase
        // An illegal instruction must not cause any architectural effect.
        ctrl.illegal = ill;
        if (ill) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.jump      = 1'b0;
            ctrl.jalr      = 1'b0;
        end
    end

endmodule

// File: rtl/rv_decode_stage.sv
// Registered decode stage: valid/ready pipeline register, flush,
// load-use bubble insertion and a saturating bubble counter.
module rv_decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    rv_decode_if.slave       bus,
    output logic [CNT_W-1:0] bubble_count
);
    logic [4:0]      d_rd;
    logic [4:0]      d_rs1;
    logic [4:0]      d_rs2;
    logic [2:0]      d_f3;
    logic [XLEN-1:0] d_imm;
    alu_op_t         d_op;
    ctrl_t           d_ctrl;
    logic            d_use1;
    logic            d_use2;
    logic            hazard;
    logic            accept;

    rv_decode_comb #(
        .XLEN     (XLEN),
        .ENABLE_M (ENABLE_M)
    ) u_dec (
        .instr    (bus.in_instr),
        .rd       (d_rd),
        .rs1      (d_rs1),
        .rs2      (d_rs2),
        .funct3   (d_f3),
        .imm      (d_imm),
        .alu_op   (d_op),
        .ctrl     (d_ctrl),
        .uses_rs1 (d_use1),
        .uses_rs2 (d_use2)
    );

    // A load leaving this cycle cannot forward to its direct consumer.
    assign hazard = bus.out_valid && bus.out_ready
                 && bus.out_mem_read && (bus.out_rd != 5'd0)
                 && bus.in_valid
                 && ((d_use1 && d_rs1 == bus.out_rd)
                  || (d_use2 && d_rs2 == bus.out_rd));

    assign bus.in_ready = !rst && !flush && !hazard
                       && (!bus.out_valid || bus.out_ready);
    assign accept = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.out_pc        <= '0;
            bus.out_rd        <= '0;
            bus.out_rs1       <= '0;
            bus.out_rs2       <= '0;
            bus.out_funct3    <= '0;
            bus.out_imm       <= '0;
            bus.out_alu_op    <= ALU_ADD;
            bus.out_reg_write <= 1'b0;
            bus.out_alu_src   <= 1'b0;
            bus.out_jump      <= 1'b0;
            bus.out_jalr      <= 1'b0;
            bus.out_branch    <= 1'b0;
            bus.out_mem_read  <= 1'b0;
            bus.out_mem_write <= 1'b0;
            bus.out_illegal   <= 1'b0;
            bubble_count      <= '0;
        end else if (flush) begin
            bus.out_valid <= 1'b0;
        end else if (hazard) begin
            bus.out_valid <= 1'b0;
            if (bubble_count != '1)
                bubble_count <= bubble_count + CNT_W'(1);
        end else if (accept) begin
            bus.out_valid     <= 1'b1;
            bus.out_pc        <= bus.in_pc;
            bus.out_rd        <= d_rd;
            bus.out_rs1       <= d_rs1;
            bus.out_rs2       <= d_rs2;
            bus.out_funct3    <= d_f3;
            bus.out_imm       <= d_imm;
            bus.out_alu_op    <= d_op;
            bus.out_reg_write <= d_ctrl.reg_write;
            bus.out_alu_src   <= d_ctrl.alu_src;
            bus.out_jump      <= d_ctrl.jump;
            bus.out_jalr      <= d_ctrl.jalr;
            bus.out_branch    <= d_ctrl.branch;
            bus.out_mem_read  <= d_ctrl.mem_read;
            bus.out_mem_write <= d_ctrl.mem_write;
            bus.out_illegal   <= d_ctrl.illegal;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
